input_fetch_ctrl: RTL

Read sequencer for the 64K x 8 input image SRAM. Each SRAM read returns 4 consecutive signed bytes, and data is valid one cycle after the address is presented. On start, the block walks an IMG_H x IMG_W image and emits an FFT_N x FFT_N zero-padded pixel stream, in row-major order, to the FFT row engine over a valid/ready handshake. The block never writes the SRAM.

---
 rtl/input_fetch_if.sv | 57 +++++
 rtl/input_fetch_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/input_fetch_if.sv
// ---------------------------------------------------------------------------
// input_fetch_if
//   Signal bundle between input_fetch_ctrl, the input image SRAM and the FFT
//   row engine.
//
//   Ports (as seen from the master = input_fetch_ctrl):
//     start        in   one-cycle frame start pulse
//     busy         out  frame in progress
//     done         out  one-cycle pulse after the last pixel handshake
//     sram_addr    out  16-bit byte address to the SRAM
//     sram_wen     out  SRAM write enable (always 0)
//     sram_q       in   32-bit SRAM read data, byte k = pixel at sram_addr+k
//     pix_valid    out  pixel stream valid
//     pix_ready    in   downstream accept
//     pix_data     out  signed 8-bit pixel
//     pix_col_last out  last column of a padded row
//     pix_last     out  last pixel of the padded frame
//
//   Pixel handshake: a pixel transfers on a rising edge where pix_valid and
//   pix_ready are both high. Once pix_valid is raised, pix_valid, pix_data,
//   pix_col_last and pix_last hold unchanged until that transfer happens;
//   pix_ready may change on any cycle and never feeds back combinationally
//   into pix_valid.
// ---------------------------------------------------------------------------
interface input_fetch_if;
   logic        start;
   logic        busy;
   logic        done;
   logic [15:0] sram_addr;
   logic        sram_wen;
   logic [31:0] sram_q;
   logic        pix_valid;
   logic        pix_ready;
   logic [7:0]  pix_data;
   logic        pix_col_last;
   logic        pix_last;

   modport master (
      input  start,
      output busy, done,
      output sram_addr, sram_wen,
      input  sram_q,
      output pix_valid,
      input  pix_ready,
      output pix_data, pix_col_last, pix_last
   );

   modport slave (
      output start,
      input  busy, done,
      input  sram_addr, sram_wen,
      output sram_q,
      input  pix_valid,
      output pix_ready,
      input  pix_data, pix_col_last, pix_last
   );
endinterface

// File: rtl/input_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// input_fetch_ctrl
//   Read sequencer for the 64K x 8 input image SRAM. On start it walks an
//   IMG_H x IMG_W image and emits an FFT_N x FFT_N zero-padded pixel stream
//   in row-major order. Each SRAM read returns 4 bytes, valid one cycle after
//   the address is presented; the SRAM is never written.
//
//   Parameters: IMG_H, IMG_W (1..FFT_N), FFT_N (power of 2, 4..256),
//               BASE_ADDR (byte address of pixel (0,0), wraps modulo 2^16).
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     bus        input_fetch_if.master (start/busy/done, SRAM, pixel stream)
//     dbg_state  current FSM state encoding (state_t)
//
//   Build option INPUT_FETCH_PREFETCH_EN: adds a second group buffer that is
//   filled while the current group emits lanes 1..3, giving 1 pixel/cycle.
//   Without it, a valid group takes 6 cycles and a padding group 5 cycles.
// ---------------------------------------------------------------------------
module input_fetch_ctrl #(
   parameter int          IMG_H     = 28,
   parameter int          IMG_W     = 28,
   parameter int          FFT_N     = 32,
   parameter logic [15:0] BASE_ADDR = 16'h0000
) (
   input  logic          clk,
   input  logic          rst,
   input_fetch_if.master bus,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_ZLOAD = 3'd3,
      S_EMIT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [8:0]  row_q, row_d, col_q, col_d;
   logic [1:0]  lane_q, lane_d;
   logic [15:0] row_base_q, row_base_d;
   logic [15:0] addr_q, addr_d;
   logic [31:0] buf_q, buf_d;

   logic        col_wrap, last_grp, nxt_fetch, hs;
   logic [8:0]  nxt_col, nxt_row;
   logic [15:0] nxt_row_base;

`ifdef INPUT_FETCH_PREFETCH_EN
   typedef enum logic [1:0] {PF_EMPTY, PF_WAIT, PF_FULL} pf_t;
   pf_t         pf_q, pf_d;
   logic [31:0] nbuf_q, nbuf_d;
`endif

   // Zero every lane whose column lies at or past the image row end, so bytes
   // belonging to the next image row are never forwarded.
   function automatic logic [31:0] mask_group(input logic [31:0] q, input logic [8:0] c);
      logic [31:0] m;
      m = q;
      for (int k = 0; k < 4; k++) begin
         if (int'(c) + k >= IMG_W) m[8*k +: 8] = 8'h00;
      end
      return m;
   endfunction

   // Position of the group that follows the current one.
   always_comb begin
      col_wrap     = (col_q == 9'(FFT_N - 4));
      nxt_col      = col_wrap ? 9'd0 : col_q + 9'd4;
      nxt_row      = col_wrap ? row_q + 9'd1 : row_q;
      nxt_row_base = col_wrap ? row_base_q + 16'(IMG_W) : row_base_q;
      last_grp     = col_wrap && (row_q == 9'(FFT_N - 1));
      nxt_fetch    = (nxt_row < 9'(IMG_H)) && (nxt_col < 9'(IMG_W));
   end

   assign hs = (state_q == S_EMIT) && bus.pix_ready;

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      lane_d     = lane_q;
      row_base_d = row_base_q;
      addr_d     = addr_q;
      buf_d      = buf_q;
`ifdef INPUT_FETCH_PREFETCH_EN
      pf_d       = pf_q;
      nbuf_d     = nbuf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               row_d      = '0;
               col_d      = '0;
               lane_d     = '0;
               row_base_d = BASE_ADDR;
               state_d    = (IMG_H > 0 && IMG_W > 0) ? S_FETCH : S_ZLOAD;
            end
         end
         S_FETCH: begin
            addr_d  = row_base_q + {7'd0, col_q};
            state_d = S_LOAD;
         end
         S_LOAD: begin
            buf_d   = mask_group(bus.sram_q, col_q);
            state_d = S_EMIT;
         end
         S_ZLOAD: begin
            buf_d   = '0;
            state_d = S_EMIT;
         end
         S_EMIT: begin
            if (hs) begin
               lane_d = lane_q + 2'd1;
               if (lane_q == 2'd3) begin
                  col_d      = nxt_col;
                  row_d      = nxt_row;
                  row_base_d = nxt_row_base;
                  if (last_grp) begin
                     state_d    = S_DONE;
                     col_d      = '0;
                     row_d      = '0;
                     row_base_d = BASE_ADDR;
                  end else begin
`ifdef INPUT_FETCH_PREFETCH_EN
                     // The prefetch buffer is always full by lane 3: it is
                     // issued on the lane-1 cycle and completes one cycle later.
                     buf_d = nbuf_q;
`else
                     state_d = nxt_fetch ? S_FETCH : S_ZLOAD;
`endif
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

`ifdef INPUT_FETCH_PREFETCH_EN
      case (pf_q)
         PF_EMPTY: begin
            if (state_q == S_EMIT && lane_q != 2'd0 && !last_grp) begin
               if (nxt_fetch) begin
                  addr_d = nxt_row_base + {7'd0, nxt_col};
                  pf_d   = PF_WAIT;
               end else begin
                  nbuf_d = '0;
                  pf_d   = PF_FULL;
               end
            end
         end
         PF_WAIT: begin
            // Counters still point at the current group, so nxt_col is the
            // column of the data arriving now.
            nbuf_d = mask_group(bus.sram_q, nxt_col);
            pf_d   = PF_FULL;
         end
         PF_FULL: begin
            if (hs && lane_q == 2'd3) pf_d = PF_EMPTY;
         end
         default: pf_d = PF_EMPTY;
      endcase
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         lane_q     <= '0;
         row_base_q <= BASE_ADDR;
         addr_q     <= '0;
         buf_q      <= '0;
`ifdef INPUT_FETCH_PREFETCH_EN
         pf_q       <= PF_EMPTY;
         nbuf_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         lane_q     <= lane_d;
         row_base_q <= row_base_d;
         addr_q     <= addr_d;
         buf_q      <= buf_d;
`ifdef INPUT_FETCH_PREFETCH_EN
         pf_q       <= pf_d;
         nbuf_q     <= nbuf_d;
`endif
      end
   end

   // The address is presented in the issuing cycle and then held in addr_q.
   assign bus.sram_addr    = addr_d;
   assign bus.sram_wen     = 1'b0;
   assign bus.busy         = (state_q != S_IDLE) && (state_q != S_DONE);
   assign bus.done         = (state_q == S_DONE);
   assign bus.pix_valid    = (state_q == S_EMIT);
   assign bus.pix_data     = (state_q == S_EMIT) ? buf_q[{lane_q, 3'b000} +: 8] : 8'h00;
   assign bus.pix_col_last = (state_q == S_EMIT) && col_wrap && (lane_q == 2'd3);
   assign bus.pix_last     = bus.pix_col_last && (row_q == 9'(FFT_N - 1));
   assign dbg_state        = state_q;

endmodule
